// File: rtl/quad_stim_pkg.sv
// ============================================================================
// quad_stim_pkg : states, A/B phase constants and phase lookup for quad_stim_gen
// Revision 1.0
// ============================================================================
`default_nettype none

package quad_stim_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PH1  = 3'd1,
        PH2  = 3'd2,
        PH3  = 3'd3,
        PH4  = 3'd4
    } state_e;

    localparam int unsigned POS_MAX_DEFAULT = 19;

    localparam logic [1:0] AB_DETENT = 2'b11;
    localparam logic [1:0] AB_R1     = 2'b10;
    localparam logic [1:0] AB_R3     = 2'b01;
    localparam logic [1:0] AB_L1     = 2'b01;
    localparam logic [1:0] AB_L3     = 2'b10;
    localparam logic [1:0] AB_MID    = 2'b00;

    // {A,B} for a given direction (1 = right) and state; anything else rests at the detent
    function automatic logic [1:0] phase_ab(input logic dir, input state_e st);
        case (st)
            PH1:     return dir ? AB_R1 : AB_L1;
            PH2:     return AB_MID;
            PH3:     return dir ? AB_R3 : AB_L3;
            default: return AB_DETENT;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/quad_stim_gen_phase_timer.sv
// ============================================================================
// quad_stim_gen_phase_timer : loadable down-counter, expire high at zero
// Revision 1.0
// ============================================================================
`default_nettype none

module quad_stim_gen_phase_timer #(
    parameter int PHASE_W = 16
) (
    input  logic               clk,
    input  logic               rst_ni,
    input  logic               load_i,
    input  logic [PHASE_W-1:0] load_val_i,
    output logic               expire_o
);

    logic [PHASE_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/quad_stim_gen.sv
// ============================================================================
// quad_stim_gen : click commands in, registered A/B quadrature plus mirror position out
// Revision 1.0
// ============================================================================
`default_nettype none

module quad_stim_gen
    import quad_stim_pkg::*;
#(
    parameter int PHASE_W = 16,
    parameter int CNT_W   = 8,
    parameter int POS_MAX = POS_MAX_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_ni,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic               cmd_dir_i,
    input  logic [CNT_W-1:0]   cmd_clicks_i,
    input  logic [PHASE_W-1:0] phase_len_i,
    input  logic               abort_i,
    input  logic               pos_clr_i,
    output logic               A_o,
    output logic               B_o,
    output logic [4:0]         pos_o,
    output logic               busy_o,
    output logic               done_o
);

    state_e             state_q, state_d;
    logic [1:0]         ab_q, ab_d;
    logic [4:0]         pos_q, pos_d;
    logic               dir_q, dir_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic [PHASE_W-1:0] len_m1_q, len_m1_d;
    logic               abort_q, abort_d;
    logic               done_q, done_d;
    logic               accept;
    logic               tmr_load;
    logic               tmr_expire;

    assign cmd_ready_o = (state_q == IDLE);
    assign accept      = cmd_valid_i & cmd_ready_o;

    quad_stim_gen_phase_timer #(
        .PHASE_W (PHASE_W)
    ) u_phase_timer (
        .clk        (clk),
        .rst_ni     (rst_ni),
        .load_i     (tmr_load),
        .load_val_i (len_m1_d),
        .expire_o   (tmr_expire)
    );

    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        rem_d    = rem_q;
        len_m1_d = len_m1_q;
        done_d   = 1'b0;
        tmr_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    dir_d    = cmd_dir_i;
                    rem_d    = cmd_clicks_i;
                    len_m1_d = (phase_len_i == '0) ? '0 : phase_len_i - 1'b1;
                    tmr_load = 1'b1;
                    if (cmd_clicks_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = PH1;
                    end
                end
            end
            PH1: if (tmr_expire) begin state_d = PH2; tmr_load = 1'b1; end
            PH2: if (tmr_expire) begin state_d = PH3; tmr_load = 1'b1; end
            PH3: if (tmr_expire) begin state_d = PH4; tmr_load = 1'b1; end
            PH4: begin
                if (tmr_expire) begin
                    rem_d    = rem_q - 1'b1;
                    tmr_load = 1'b1;
                    // An abort raised in the very last cycle still stops after this click
                    if ((rem_q != CNT_W'(1)) && !(abort_q || abort_i)) begin
                        state_d = PH1;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        abort_d = (state_q != IDLE) && (state_d != IDLE) && (abort_q || abort_i);

        pos_d = pos_q;
        if ((state_q == PH3) && (state_d == PH4)) begin
            if (dir_q) begin
                pos_d = (pos_q == 5'(POS_MAX)) ? 5'd0 : pos_q + 5'd1;
            end else begin
                pos_d = (pos_q == 5'd0) ? 5'(POS_MAX) : pos_q - 5'd1;
            end
        end
        if (pos_clr_i) begin
            pos_d = 5'd0;
        end

        ab_d = phase_ab(dir_d, state_d);
    end

    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            ab_q     <= AB_DETENT;
            pos_q    <= 5'd0;
            dir_q    <= 1'b0;
            rem_q    <= '0;
            len_m1_q <= '0;
            abort_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ab_q     <= ab_d;
            pos_q    <= pos_d;
            dir_q    <= dir_d;
            rem_q    <= rem_d;
            len_m1_q <= len_m1_d;
            abort_q  <= abort_d;
            done_q   <= done_d;
        end
    end

    assign A_o    = ab_q[1];
    assign B_o    = ab_q[0];
    assign pos_o  = pos_q;
    assign busy_o = ~cmd_ready_o;
    assign done_o = done_q;

endmodule

`default_nettype wire

// File: tb/tb_quad_stim_gen.sv
// ============================================================================
// tb_quad_stim_gen : directed self-checking bench for quad_stim_gen
// Revision 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_quad_stim_gen;

    localparam int PW = 16;
    localparam int CW = 8;
    localparam int PM = 19;

    logic          clk = 1'b0;
    logic          rst_ni;
    logic          cmd_valid_i;
    logic          cmd_ready_o;
    logic          cmd_dir_i;
    logic [CW-1:0] cmd_clicks_i;
    logic [PW-1:0] phase_len_i;
    logic          abort_i;
    logic          pos_clr_i;
    logic          A_o;
    logic          B_o;
    logic [4:0]    pos_o;
    logic          busy_o;
    logic          done_o;

    always #5 clk = ~clk;

    quad_stim_gen #(
        .PHASE_W (PW),
        .CNT_W   (CW),
        .POS_MAX (PM)
    ) dut (
        .clk          (clk),
        .rst_ni       (rst_ni),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_dir_i    (cmd_dir_i),
        .cmd_clicks_i (cmd_clicks_i),
        .phase_len_i  (phase_len_i),
        .abort_i      (abort_i),
        .pos_clr_i    (pos_clr_i),
        .A_o          (A_o),
        .B_o          (B_o),
        .pos_o        (pos_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0] seq_r [4];
    logic [1:0] seq_l [4];

    // Reference decoder: a return to 11 from 01 is a right click, from 10 a left click
    logic [1:0] dec_prev;
    int         dec_pos;
    always @(posedge clk) begin
        if (!rst_ni) begin
            dec_pos  <= 0;
            dec_prev <= 2'b11;
        end else begin
            if (dec_prev != 2'b11 && {A_o, B_o} == 2'b11) begin
                if (dec_prev == 2'b01) dec_pos <= (dec_pos == PM) ? 0 : dec_pos + 1;
                else                   dec_pos <= (dec_pos == 0) ? PM : dec_pos - 1;
            end
            dec_prev <= {A_o, B_o};
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int pos_after(input int start, input logic dir, input int e);
        if (dir) return (start + e) % (PM + 1);
        return (start + (PM + 1) - (e % (PM + 1))) % (PM + 1);
    endfunction

    task automatic reset_dut();
        rst_ni = 1'b0;
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
    endtask

    // Offers a command at the current negedge and checks every cycle through the done cycle
    task automatic run_cmd(input logic dir, input int clicks, input int len_in,
                           input int abort_k, input int start);
        int len, n_eff, last, p, c;
        logic [1:0] exp_ab;
        len   = (len_in == 0) ? 1 : len_in;
        n_eff = clicks;
        if (abort_k > 0) n_eff = (abort_k - 1) / (4 * len) + 1;
        last  = 4 * n_eff * len + 1;
        cmd_valid_i  = 1'b1;
        cmd_dir_i    = dir;
        cmd_clicks_i = clicks[CW-1:0];
        phase_len_i  = len_in[PW-1:0];
        check_val("ready_at_offer", cmd_ready_o, 1);
        @(negedge clk);
        cmd_valid_i = 1'b0;
        for (int k = 1; k <= last; k++) begin
            abort_i = (k == abort_k);
            if (k < last) begin
                p = ((k - 1) / len) % 4;
                c = (k - 1) / (4 * len);
                exp_ab = dir ? seq_r[p] : seq_l[p];
                check_val($sformatf("ab_k%0d", k), {A_o, B_o}, exp_ab);
                check_val($sformatf("busy_k%0d", k), busy_o, 1);
                check_val($sformatf("ready_k%0d", k), cmd_ready_o, 0);
                check_val($sformatf("done_k%0d", k), done_o, 0);
                check_val($sformatf("pos_k%0d", k), pos_o,
                          pos_after(start, dir, c + ((p == 3) ? 1 : 0)));
            end else begin
                check_val("ab_done", {A_o, B_o}, 2'b11);
                check_val("busy_done", busy_o, 0);
                check_val("ready_done", cmd_ready_o, 1);
                check_val("done_pulse", done_o, 1);
                check_val("pos_done", pos_o, pos_after(start, dir, n_eff));
            end
            if (k < last) @(negedge clk);
        end
        abort_i = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        seq_r[0] = 2'b10; seq_r[1] = 2'b00; seq_r[2] = 2'b01; seq_r[3] = 2'b11;
        seq_l[0] = 2'b01; seq_l[1] = 2'b00; seq_l[2] = 2'b10; seq_l[3] = 2'b11;
        cmd_valid_i  = 1'b0;
        cmd_dir_i    = 1'b0;
        cmd_clicks_i = '0;
        phase_len_i  = '0;
        abort_i      = 1'b0;
        pos_clr_i    = 1'b0;
        rst_ni       = 1'b0;
        @(negedge clk);
        reset_dut();

        check_val("rst_ab", {A_o, B_o}, 2'b11);
        check_val("rst_pos", pos_o, 0);
        check_val("rst_busy", busy_o, 0);
        check_val("rst_done", done_o, 0);
        check_val("rst_ready", cmd_ready_o, 1);

        // Right, 3 clicks, L=4: done at T+49, pos 3
        run_cmd(1'b1, 3, 4, 0, 0);
        repeat (3) @(negedge clk);
        check_val("r3_done_drop", done_o, 0);
        check_val("r3_dec_pos", dec_pos, 3);

        // Left from reset, 1 click, L=1: pos wraps 0 -> 19
        reset_dut();
        run_cmd(1'b0, 1, 1, 0, 0);
        repeat (3) @(negedge clk);
        check_val("l1_dec_pos", dec_pos, PM);

        // 21 right clicks with phase_len 0: 84 busy cycles, ends at 1
        reset_dut();
        run_cmd(1'b1, 21, 0, 0, 0);
        repeat (3) @(negedge clk);
        check_val("wrap_pos", pos_o, 1);
        check_val("wrap_dec_pos", dec_pos, 1);

        // Abort in PH2 of click 2 of 5 (L=3): stops after click 2
        reset_dut();
        run_cmd(1'b1, 5, 3, 17, 0);
        @(negedge clk);
        check_val("abort_idle_ab", {A_o, B_o}, 2'b11);
        check_val("abort_idle_busy", busy_o, 0);
        check_val("abort_pos", pos_o, 2);

        // Zero clicks: done next cycle, A/B stay at detent
        run_cmd(1'b1, 0, 5, 0, 2);
        @(negedge clk);
        check_val("zero_done_drop", done_o, 0);
        check_val("zero_ab", {A_o, B_o}, 2'b11);

        // Reset during PH3 of click 2 (right, L=4)
        reset_dut();
        cmd_valid_i = 1'b1; cmd_dir_i = 1'b1; cmd_clicks_i = 8'd2; phase_len_i = 16'd4;
        @(negedge clk);
        cmd_valid_i = 1'b0;
        repeat (24) @(negedge clk);
        check_val("mid_ab_ph3", {A_o, B_o}, 2'b01);
        check_val("mid_pos", pos_o, 1);
        rst_ni = 1'b0;
        @(negedge clk);
        check_val("mid_rst_ab", {A_o, B_o}, 2'b11);
        check_val("mid_rst_pos", pos_o, 0);
        check_val("mid_rst_busy", busy_o, 0);
        check_val("mid_rst_done", done_o, 0);
        rst_ni = 1'b1;
        @(negedge clk);
        check_val("mid_after_done", done_o, 0);
        check_val("mid_after_busy", busy_o, 0);

        // pos_clr coincident with PH4 entry wins over the increment
        run_cmd(1'b1, 1, 2, 0, 0);
        cmd_valid_i = 1'b1; cmd_dir_i = 1'b1; cmd_clicks_i = 8'd1; phase_len_i = 16'd2;
        @(negedge clk);
        cmd_valid_i = 1'b0;
        repeat (5) @(negedge clk);
        check_val("clr_pre_ab", {A_o, B_o}, 2'b01);
        check_val("clr_pre_pos", pos_o, 1);
        pos_clr_i = 1'b1;
        @(negedge clk);
        pos_clr_i = 1'b0;
        check_val("clr_ph4_ab", {A_o, B_o}, 2'b11);
        check_val("clr_ph4_pos", pos_o, 0);
        check_val("clr_ph4_busy", busy_o, 1);
        repeat (2) @(negedge clk);
        check_val("clr_done", done_o, 1);
        check_val("clr_final_pos", pos_o, 0);

        // Back-to-back: accepted in the done cycle, two left clicks from 0
        run_cmd(1'b0, 2, 1, 0, 0);
        @(negedge clk);
        check_val("b2b_pos", pos_o, 18);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
